// File: rtl/clock_div_cfg_pkg.sv
// Shared types and constants for the clock divider configuration sequencer.
package clock_div_cfg_pkg;

  localparam int unsigned DIV_W_DEFAULT = 8;

  // Divider settings the macro sees out of reset (divide by exactly 1).
  localparam int unsigned MFI_RST = 1;
  localparam int unsigned MFN_RST = 0;
  localparam int unsigned MFD_RST = 1;

  typedef enum logic [1:0] {
    OpDisable = 2'd0,
    OpEnable  = 2'd1,
    OpUpdate  = 2'd2,
    OpRsvd    = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    RespOk      = 2'd0,
    RespIllegal = 2'd1,
    RespTimeout = 2'd2
  } resp_code_e;

  typedef enum logic [2:0] {
    StIdle,
    StEnWait,
    StLoad,
    StUpdReq,
    StUpdRel,
    StResp,
    StFault
  } state_e;

endpackage

// File: rtl/clock_div_config_sequencer_if.sv
// Local request/response port of the sequencer: valid/ready request, pulsed response.
interface clock_div_config_sequencer_if
  import clock_div_cfg_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEFAULT
);

  logic             req_valid;
  logic             req_ready;
  op_e              req_op;
  logic [DIV_W-1:0] req_mfi;
  logic [DIV_W-1:0] req_mfn;
  logic [DIV_W-1:0] req_mfd;
  logic             resp_valid;
  resp_code_e       resp_code;
  logic             busy;

  modport master (
    output req_valid, req_op, req_mfi, req_mfn, req_mfd,
    input  req_ready, resp_valid, resp_code, busy
  );

  modport slave (
    input  req_valid, req_op, req_mfi, req_mfn, req_mfd,
    output req_ready, resp_valid, resp_code, busy
  );

endinterface

// File: rtl/clock_div_ack_sync.sv
// Single-bit multi-flop synchroniser, all stages cleared by the async reset.
module clock_div_ack_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic async_resetn,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/clock_div_config_sequencer.sv
// Sequences enable/disable/update requests onto the clock divider macro handshakes,
// with synchronised acks and a shared wait timeout.
module clock_div_config_sequencer
  import clock_div_cfg_pkg::*;
#(
  parameter int unsigned DIV_W          = DIV_W_DEFAULT,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                         clock,
  input  logic                         async_resetn,
  clock_div_config_sequencer_if.slave  bus,
  output logic                         async_enable,
  input  logic                         async_enable_ack,
  output logic                         async_update,
  input  logic                         async_update_ack,
  output logic [DIV_W-1:0]             mfi,
  output logic [DIV_W-1:0]             mfn,
  output logic [DIV_W-1:0]             mfd
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  state_e           state_q;
  logic             ready_q, busy_q, resp_valid_q;
  resp_code_e       resp_code_q;
  logic             enable_q, update_q;
  logic [DIV_W-1:0] mfi_q, mfn_q, mfd_q;
  logic [CntW-1:0]  cnt_q;

  logic en_ack_s, upd_ack_s;
  logic upd_illegal;
  logic wait_done;

  clock_div_ack_sync #(.SYNC_STAGES(SYNC_STAGES)) u_en_sync (
    .clock        (clock),
    .async_resetn (async_resetn),
    .d            (async_enable_ack),
    .q            (en_ack_s)
  );

  clock_div_ack_sync #(.SYNC_STAGES(SYNC_STAGES)) u_upd_sync (
    .clock        (clock),
    .async_resetn (async_resetn),
    .d            (async_update_ack),
    .q            (upd_ack_s)
  );

  assign upd_illegal = (bus.req_mfi == '0) || (bus.req_mfd == '0) ||
                       (bus.req_mfn >= bus.req_mfd);

  always_comb begin
    case (state_q)
      StEnWait: wait_done = (en_ack_s == enable_q);
      StUpdReq: wait_done = upd_ack_s;
      StUpdRel: wait_done = !upd_ack_s;
      default:  wait_done = 1'b0;
    endcase
  end

  // ready/busy are defaulted to "not idle" and overridden on every path into StIdle.
  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      state_q      <= StIdle;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_code_q  <= RespOk;
      enable_q     <= 1'b0;
      update_q     <= 1'b0;
      mfi_q        <= DIV_W'(MFI_RST);
      mfn_q        <= DIV_W'(MFN_RST);
      mfd_q        <= DIV_W'(MFD_RST);
      cnt_q        <= '0;
    end else begin
      ready_q      <= 1'b0;
      busy_q       <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_code_q  <= RespOk;
      cnt_q        <= '0;
      case (state_q)
        StIdle: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          if (bus.req_valid && ready_q) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            case (bus.req_op)
              OpDisable, OpEnable: begin
                enable_q <= bus.req_op[0];
                state_q  <= StEnWait;
              end
              OpUpdate: begin
                if (upd_illegal) begin
                  resp_valid_q <= 1'b1;
                  resp_code_q  <= RespIllegal;
                  state_q      <= StResp;
                end else begin
                  mfi_q   <= bus.req_mfi;
                  mfn_q   <= bus.req_mfn;
                  mfd_q   <= bus.req_mfd;
                  state_q <= StLoad;
                end
              end
              default: begin
                resp_valid_q <= 1'b1;
                resp_code_q  <= RespIllegal;
                state_q      <= StResp;
              end
            endcase
          end
        end
        StLoad: begin
          update_q <= 1'b1;
          state_q  <= StUpdReq;
        end
        StEnWait, StUpdReq, StUpdRel: begin
          // Exit condition has priority over the timeout threshold.
          if (wait_done) begin
            if (state_q == StUpdReq) begin
              update_q <= 1'b0;
              state_q  <= StUpdRel;
            end else begin
              resp_valid_q <= 1'b1;
              state_q      <= StResp;
            end
          end else if (cnt_q == CntLast) begin
            update_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_code_q  <= RespTimeout;
            state_q      <= StFault;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StResp: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        StFault: begin
          // Wait for the macro to settle before accepting anything new.
          if (!upd_ack_s && (en_ack_s == enable_q)) begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_code  = resp_code_q;
  assign bus.busy       = busy_q;
  assign async_enable   = enable_q;
  assign async_update   = update_q;
  assign mfi            = mfi_q;
  assign mfn            = mfn_q;
  assign mfd            = mfd_q;

endmodule
